// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port unified memory between an instruction
// fetch port and a data load/store port. Data wins over fetch. Every access
// completes with exactly one ready or err pulse unless reset abandons it.
//
// Handshake: a CPU request (if_req, d_rd/d_wr) is held until the matching
// x_ready or x_err pulse. The memory side is a req/ack pair: mem_req and its
// address/data stay constant until mem_ack is seen or the wait limit expires.
module mem_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        d_rd,
   input  logic        d_wr,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stall,
   output logic        if_err,
   output logic        d_err,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_if_rdata;
   logic [31:0] r_d_rdata;
   logic        r_we;
   logic        r_is_d;
   logic        r_ok;
   logic        r_proto;
   logic [15:0] r_cnt;
   logic        w_busy;
   logic        w_d_req;
   logic        w_limit;
   logic        w_resp;

   assign w_busy  = (r_state == BUSY_I) || (r_state == BUSY_D);
   assign w_resp  = (r_state == RESP);
   assign w_d_req = d_rd | d_wr;
   // Last permitted wait cycle: the counter reaches TIMEOUT at its end.
   assign w_limit = (r_cnt == 16'(TIMEOUT - 1));

   // State register; reset drops any access in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next-state: data has priority, RESP always lasts one cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_d_req)     w_next = BUSY_D;
            else if (if_req) w_next = BUSY_I;
         end
         BUSY_I, BUSY_D: begin
            if (mem_ack || w_limit) w_next = RESP;
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Request capture, wait counter, outcome flag and read-data capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr     <= '0;
         r_wdata    <= '0;
         r_we       <= 1'b0;
         r_is_d     <= 1'b0;
         r_ok       <= 1'b0;
         r_proto    <= 1'b0;
         r_cnt      <= '0;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
      end else begin
         if (r_state == IDLE) begin
            if (w_d_req) begin
               r_addr  <= d_addr;
               r_wdata <= d_wdata;
               r_we    <= d_wr;
               r_is_d  <= 1'b1;
               r_proto <= d_rd & d_wr;
               r_cnt   <= '0;
            end else if (if_req) begin
               r_addr  <= if_addr;
               r_we    <= 1'b0;
               r_is_d  <= 1'b0;
               r_proto <= 1'b0;
               r_cnt   <= '0;
            end
         end else if (w_busy) begin
            if (mem_ack) begin
               // Ack on the last wait cycle still counts as success.
               r_ok <= 1'b1;
               if (r_state == BUSY_I)  r_if_rdata <= mem_rdata;
               else if (!r_we)         r_d_rdata  <= mem_rdata;
            end else begin
               r_cnt <= r_cnt + 16'd1;
               if (w_limit) r_ok <= 1'b0;
            end
         end
      end
   end

   assign mem_req   = w_busy;
   assign mem_we    = w_busy & r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign if_rdata  = r_if_rdata;
   assign d_rdata   = r_d_rdata;

   // A conflicting rd+wr completes its write but reports an error.
   assign if_ready  = w_resp & ~r_is_d & r_ok;
   assign if_err    = w_resp & ~r_is_d & ~r_ok;
   assign d_ready   = w_resp & r_is_d & r_ok & ~r_proto;
   assign d_err     = w_resp & r_is_d & (~r_ok | r_proto);

   assign stall = (if_req & ~if_ready & ~if_err) | (w_d_req & ~d_ready & ~d_err);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a short wait limit (TIMEOUT=4).
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        d_rd;
   logic        d_wr;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stall;
   logic        if_err;
   logic        d_err;
   logic [1:0]  dbg_state;

   int checks = 0;
   int failures = 0;

   mem_arbiter #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall(stall), .if_err(if_err), .d_err(d_err), .dbg_state(dbg_state)
   );

   // Clock: 10 time-unit period.
   always #5 clk = ~clk;

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; if_req = 0; if_addr = 0; d_rd = 0; d_wr = 0;
      d_addr = 0; d_wdata = 0; mem_rdata = 0; mem_ack = 0;
      #1;
      checks++;
      if ({mem_req, mem_we, if_ready, d_ready, if_err, d_err} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b want=000000", {mem_req, mem_we, if_ready, d_ready, if_err, d_err});
      end
      checks++;
      if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'd0 || dbg_state !== 2'd0) begin
         failures++;
         $display("FAIL reset_data addr=%h wdata=%h irdata=%h drdata=%h state=%0d want all 0",
                  mem_addr, mem_wdata, if_rdata, d_rdata, dbg_state);
      end
      step(); step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_fetch();
      if_req = 1; if_addr = 32'h0000_0040;
      #1;
      checks++;
      if (stall !== 1'b1) begin failures++; $display("FAIL fetch_stall0 got=%b want=1", stall); end
      step();  // N+1
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin
         failures++;
         $display("FAIL fetch_memreq req=%b we=%b addr=%h want 1 0 00000040", mem_req, mem_we, mem_addr);
      end
      mem_ack = 1; mem_rdata = 32'h0010_0093;
      step();  // N+2
      mem_ack = 0; mem_rdata = 32'hFFFF_FFFF;
      checks++;
      if (if_ready !== 1'b1 || if_rdata !== 32'h0010_0093 || stall !== 1'b0 || mem_req !== 1'b0) begin
         failures++;
         $display("FAIL fetch_ready rdy=%b rdata=%h stall=%b req=%b want 1 00100093 0 0",
                  if_ready, if_rdata, stall, mem_req);
      end
      if_req = 0;
      step();
      checks++;
      if (if_ready !== 1'b0 || stall !== 1'b0 || dbg_state !== 2'd0) begin
         failures++;
         $display("FAIL fetch_after rdy=%b stall=%b state=%0d want 0 0 0", if_ready, stall, dbg_state);
      end
   endtask

   task automatic test_simultaneous();
      if_req = 1; if_addr = 32'h200;
      d_wr = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
      step();
      checks++;
      if (mem_req !== 1 || mem_we !== 1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF || stall !== 1) begin
         failures++;
         $display("FAIL sim_store req=%b we=%b addr=%h wdata=%h stall=%b want 1 1 00000100 deadbeef 1",
                  mem_req, mem_we, mem_addr, mem_wdata, stall);
      end
      mem_ack = 1;
      step();
      mem_ack = 0;
      checks++;
      if (d_ready !== 1 || if_ready !== 0 || stall !== 1 || mem_req !== 0) begin
         failures++;
         $display("FAIL sim_resp dready=%b iready=%b stall=%b req=%b want 1 0 1 0", d_ready, if_ready, stall, mem_req);
      end
      d_wr = 0;
      step();  // IDLE, fetch sampled now
      checks++;
      if (mem_req !== 0 || stall !== 1) begin
         failures++;
         $display("FAIL sim_idle req=%b stall=%b want 0 1", mem_req, stall);
      end
      step();
      checks++;
      if (mem_req !== 1 || mem_we !== 0 || mem_addr !== 32'h200) begin
         failures++;
         $display("FAIL sim_fetch req=%b we=%b addr=%h want 1 0 00000200", mem_req, mem_we, mem_addr);
      end
      mem_ack = 1; mem_rdata = 32'h0000_0013;
      step();
      mem_ack = 0;
      checks++;
      if (if_ready !== 1 || if_rdata !== 32'h13 || stall !== 0) begin
         failures++;
         $display("FAIL sim_fetch_rdy rdy=%b rdata=%h stall=%b want 1 00000013 0", if_ready, if_rdata, stall);
      end
      if_req = 0;
      step();
   endtask

   task automatic test_ack_at_limit();
      d_rd = 1; d_addr = 32'h400;
      step(); step(); step(); step();  // 4th BUSY cycle
      checks++;
      if (mem_req !== 1 || mem_addr !== 32'h400) begin
         failures++;
         $display("FAIL limit_busy req=%b addr=%h want 1 00000400", mem_req, mem_addr);
      end
      mem_ack = 1; mem_rdata = 32'hCAFE_0001;
      step();
      mem_ack = 0; mem_rdata = 0;
      checks++;
      if (d_ready !== 1 || d_err !== 0 || d_rdata !== 32'hCAFE_0001) begin
         failures++;
         $display("FAIL limit_ack rdy=%b err=%b rdata=%h want 1 0 cafe0001", d_ready, d_err, d_rdata);
      end
      d_rd = 0;
      step();
   endtask

   task automatic test_timeout();
      int n;
      d_rd = 1; d_addr = 32'h300;
      step();
      n = 0;
      while (mem_req === 1'b1 && n < 20) begin
         checks++;
         if (d_ready !== 0 || d_err !== 0) begin
            failures++;
            $display("FAIL to_busy_pulse rdy=%b err=%b want 0 0", d_ready, d_err);
         end
         n++;
         step();
      end
      checks++;
      if (n !== 4) begin failures++; $display("FAIL to_req_cycles got=%0d want=4", n); end
      checks++;
      if (d_err !== 1 || d_ready !== 0 || d_rdata !== 32'hCAFE_0001) begin
         failures++;
         $display("FAIL to_resp err=%b rdy=%b rdata=%h want 1 0 cafe0001", d_err, d_ready, d_rdata);
      end
      d_rd = 0;
      step();
      checks++;
      if (d_err !== 0 || dbg_state !== 2'd0) begin
         failures++;
         $display("FAIL to_after err=%b state=%0d want 0 0", d_err, dbg_state);
      end
   endtask

   task automatic test_fetch_timeout();
      int n;
      if_req = 1; if_addr = 32'h700;
      step();
      n = 0;
      while (mem_req === 1'b1 && n < 20) begin n++; step(); end
      checks++;
      if (n !== 4 || if_err !== 1 || if_ready !== 0 || if_rdata !== 32'h13 || stall !== 0) begin
         failures++;
         $display("FAIL ito_resp n=%0d err=%b rdy=%b rdata=%h stall=%b want 4 1 0 00000013 0",
                  n, if_err, if_ready, if_rdata, stall);
      end
      if_req = 0;
      step();
   endtask

   task automatic test_reset_mid();
      if_req = 1; if_addr = 32'h500;
      step();
      checks++;
      if (mem_req !== 1) begin failures++; $display("FAIL rst_busy req=%b want 1", mem_req); end
      reset = 1;
      #1;  // no clock edge in between
      checks++;
      if (mem_req !== 0 || mem_addr !== 0) begin
         failures++;
         $display("FAIL rst_async req=%b addr=%h want 0 00000000", mem_req, mem_addr);
      end
      if_req = 0;
      step();
      reset = 0;
      mem_ack = 1; mem_rdata = 32'h1234_5678;
      step();
      mem_ack = 0;
      checks++;
      if (if_ready !== 0 || if_err !== 0 || dbg_state !== 2'd0 || mem_req !== 0 || if_rdata !== 0) begin
         failures++;
         $display("FAIL rst_stale rdy=%b err=%b state=%0d req=%b rdata=%h want 0 0 0 0 00000000",
                  if_ready, if_err, dbg_state, mem_req, if_rdata);
      end
      step();
   endtask

   task automatic test_protocol();
      // d_rdata was cleared by the previous reset.
      d_rd = 1; d_wr = 1; d_addr = 32'h600; d_wdata = 32'h1234_5678;
      step();
      checks++;
      if (mem_req !== 1 || mem_we !== 1 || mem_addr !== 32'h600 || mem_wdata !== 32'h1234_5678) begin
         failures++;
         $display("FAIL proto_write req=%b we=%b addr=%h wdata=%h want 1 1 00000600 12345678",
                  mem_req, mem_we, mem_addr, mem_wdata);
      end
      mem_ack = 1; mem_rdata = 32'hAAAA_5555;
      step();
      mem_ack = 0;
      checks++;
      if (d_err !== 1 || d_ready !== 0 || d_rdata !== 32'h0 || mem_we !== 0) begin
         failures++;
         $display("FAIL proto_resp err=%b rdy=%b rdata=%h we=%b want 1 0 00000000 0", d_err, d_ready, d_rdata, mem_we);
      end
      d_rd = 0; d_wr = 0;
      step();
      checks++;
      if (d_err !== 0 || stall !== 0) begin
         failures++;
         $display("FAIL proto_after err=%b stall=%b want 0 0", d_err, stall);
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_simultaneous();
      test_ack_at_limit();
      test_timeout();
      test_fetch_timeout();
      test_reset_mid();
      test_protocol();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
